serv_uart_rx: RTL and testbench

Wishbone-readable UART receiver that captures the serial console output a SERV core drives onto its user I/O pad. It lets the management SoC read the core's output over the user-project Wishbone port without an external UART. The block samples one 8N1 serial line, buffers received bytes in a small FIFO, and exposes data and status registers as a classic Wishbone slave. One instance is placed in `user_project_wrapper` per SERV core, with `rx_i` tied to that core's TX `io_out` bit.

---
 rtl/serv_uart_rx.sv | 169 ++++++++++++++++
 tb/tb_serv_uart_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_uart_rx.sv
// 8N1 UART receiver with a byte FIFO, readable as a Wishbone slave (DATA at 0x0, STATUS at 0x4).
// Define SERV_UART_RX_IRQ_EN to add the registered irq_o output.
module serv_uart_rx #(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        rx_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
`ifdef SERV_UART_RX_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [15:0]     DIV_HALF = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]     DIV_FULL = 16'(CLK_DIV - 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAITHI} rx_state_e;

    rx_state_e   state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        rx_meta, rxs;
    logic        expired, push, ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          overrun_q, frame_err_q;
    logic          empty, full, req, pop, push_ok, clr;
    logic [1:0]    cnt_sat;
    logic [31:0]   status, rd_data;

    logic unused;
    assign unused = ^{wbs_sel_i, wbs_adr_i[31:3], wbs_adr_i[1:0], wbs_dat_i[31:6], wbs_dat_i[3:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    assign expired = (div_q == 16'd0);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if ((state_q inside {S_START, S_DATA, S_STOP}) && !expired)
            div_d = div_q - 16'd1;
        case (state_q)
            S_IDLE:
                if (!rxs) begin
                    div_d   = DIV_HALF;
                    state_d = S_START;
                end
            S_START:
                if (expired) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        div_d   = DIV_FULL;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end
            S_DATA:
                if (expired) begin
                    shift_d = {rxs, shift_q[7:1]};
                    div_d   = DIV_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end
            S_STOP:
                if (expired) begin
                    // A low stop bit may be a break; park in WAITHI so it cannot re-trigger.
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAITHI;
                    end
                end
            S_WAITHI:
                if (rxs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign pop     = req & ~wbs_we_i & ~wbs_adr_i[2] & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign clr     = req & wbs_we_i & wbs_adr_i[2];
    assign cnt_sat = (count_q > CW'(3)) ? 2'd3 : count_q[1:0];
    assign status  = {26'd0, frame_err_q, overrun_q, full, empty, cnt_sat};
    assign rd_data = wbs_adr_i[2] ? status :
                     (empty ? 32'd0 : {23'd0, 1'b1, mem[rd_ptr]});

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wbs_ack_o   <= 1'b0;
            wbs_dat_o   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (!push_ok && pop) count_q <= count_q - CW'(1);
            overrun_q   <= (push & full & ~pop) | (overrun_q & ~(clr & wbs_dat_i[4]));
            frame_err_q <= ferr_set | (frame_err_q & ~(clr & wbs_dat_i[5]));
            wbs_ack_o   <= req;
            wbs_dat_o   <= (req & ~wbs_we_i) ? rd_data : 32'd0;
        end
    end

`ifdef SERV_UART_RX_IRQ_EN
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) irq_o <= 1'b0;
        else            irq_o <= ~empty | overrun_q | frame_err_q;
    end
`endif

endmodule

// File: tb/tb_serv_uart_rx.sv
// Directed bench for serv_uart_rx: serial frames in, Wishbone reads out, checked against a queue model.
module tb_serv_uart_rx;

    localparam int D     = 16;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_i = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = 32'd0, wdat = 32'd0;
    logic [3:0]  sel = 4'hF;
    logic        ack;
    logic [31:0] dat;
`ifdef SERV_UART_RX_IRQ_EN
    logic        irq;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  q[$];
    logic        m_ovr = 1'b0, m_ferr = 1'b0, m_ack = 1'b0;
    logic [31:0] m_dat = 32'd0;

    serv_uart_rx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .rx_i     (rx_i),
        .wbs_cyc_i(cyc),
        .wbs_stb_i(stb),
        .wbs_we_i (we),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_sel_i(sel),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat)
`ifdef SERV_UART_RX_IRQ_EN
        ,
        .irq_o    (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        int cnt;
        int sat;
        logic [1:0] s2;
        cnt = q.size();
        sat = (cnt > 3) ? 3 : cnt;
        s2  = 2'(sat);
        return {26'd0, m_ferr, m_ovr, (cnt == DEPTH), (cnt == 0), s2};
    endfunction

    // Wishbone-side model: predicts ack/data for the coming edge, compares at each falling edge.
    initial forever begin
        logic        nack;
        logic [31:0] ndat;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_ack", {31'd0, ack}, 32'd0);
            check("rst_dat", dat, 32'd0);
`ifdef SERV_UART_RX_IRQ_EN
            check("rst_irq", {31'd0, irq}, 32'd0);
`endif
            q.delete();
            m_ovr = 1'b0; m_ferr = 1'b0; m_ack = 1'b0; m_dat = 32'd0;
        end else begin
            check("ack", {31'd0, ack}, {31'd0, m_ack});
            check("dat", dat, m_dat);
            nack = cyc & stb & ~m_ack;
            ndat = 32'd0;
            if (nack && !we) begin
                if (adr[2])          ndat = m_status();
                else if (q.size() > 0) ndat = {23'd0, 1'b1, q.pop_front()};
            end else if (nack && we && adr[2]) begin
                if (wdat[5]) m_ferr = 1'b0;
                if (wdat[4]) m_ovr  = 1'b0;
            end
            m_ack = nack;
            m_dat = ndat;
        end
    end

    task automatic model_push(input logic [7:0] b);
        if (q.size() == DEPTH) m_ovr = 1'b1;
        else                   q.push_back(b);
    endtask

    // Start bit is driven just after the next rising edge; returns one cycle after the stop bit ends.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_push);
        @(posedge clk); #1;
        rx_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (D) @(posedge clk); #1;
            rx_i = b[i];
        end
        repeat (D) @(posedge clk); #1;
        rx_i = stop;
        repeat (D) @(posedge clk); #1;
        if (expect_push)  model_push(b);
        else if (!stop)   m_ferr = 1'b1;
    endtask

    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] r);
        logic got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        r = 32'd0; got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                r = dat; got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL wb_timeout: got no ack expected ack at %0t", $time);
        end
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_access(1'b0, a, 32'd0, r);
        check(name, r, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        wb_access(1'b1, a, d, r);
    endtask

    initial begin
        logic [31:0] r;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // single byte
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        rd_check("a5_status", 32'h4, 32'h01);
        rd_check("a5_data",   32'h0, 32'h1A5);
        rd_check("empty_data", 32'h0, 32'h000);
        rd_check("a5_status2", 32'h4, 32'h04);

        // overrun: nine bytes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        rd_check("ovr_status", 32'h4, 32'h1B);
        for (int i = 0; i < 8; i++) rd_check("ovr_data", 32'h0, 32'h100 + 32'(i));
        wr(32'h4, 32'h10);
        rd_check("ovr_cleared", 32'h4, 32'h04);

        // framing error followed by a held break, then a good byte
        send_frame(8'h00, 1'b0, 1'b0);
        repeat (3 * D) @(posedge clk); #1;
        rx_i = 1'b1;
        repeat (D) @(posedge clk);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        rd_check("ferr_status", 32'h4, 32'h21);
        rd_check("ferr_data",   32'h0, 32'h13C);
        wr(32'h4, 32'h20);
        rd_check("ferr_cleared", 32'h4, 32'h04);

        // short low glitch must not start a frame
        @(posedge clk); #1;
        rx_i = 1'b0;
        repeat (D / 4) @(posedge clk); #1;
        rx_i = 1'b1;
        repeat (2 * D) @(posedge clk);
        rd_check("glitch_status", 32'h4, 32'h04);
        send_frame(8'h5A, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        rd_check("glitch_after", 32'h0, 32'h15A);

        // full FIFO: DATA read ack lands on the same edge as a stop-bit push
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        rd_check("full_status", 32'h4, 32'h0B);
        #1;
        fork
            send_frame(8'hEE, 1'b1, 1'b1);
            begin
                repeat (154) @(posedge clk);
                wb_access(1'b0, 32'h0, 32'h0, r);
                check("coinc_data", r, 32'h110);
            end
        join
        repeat (5) @(posedge clk);
        rd_check("coinc_status", 32'h4, 32'h0B);
        for (int i = 1; i < 8; i++) rd_check("coinc_drain", 32'h0, 32'h110 + 32'(i));
        rd_check("coinc_last", 32'h0, 32'h1EE);

        // reset in the middle of a frame, with a byte already buffered
        send_frame(8'h77, 1'b1, 1'b1);
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (40) @(posedge clk); #1;
                rst_n = 1'b0;
                repeat (3) @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        rd_check("rst_status", 32'h4, 32'h04);
        #1;
        fork
            send_frame(8'h55, 1'b1, 1'b1);
            begin
`ifdef SERV_UART_RX_IRQ_EN
                repeat (156) @(posedge clk); #1;
                check("irq_before", {31'd0, irq}, 32'd0);
                @(posedge clk); #1;
                check("irq_after", {31'd0, irq}, 32'd1);
`endif
            end
        join
        repeat (5) @(posedge clk);
        rd_check("rst_data", 32'h0, 32'h155);
        rd_check("rst_empty", 32'h0, 32'h000);
        rd_check("rst_status2", 32'h4, 32'h04);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
